mips_alu_sequencer: RTL and testbench

Multi-cycle control sequencer that fetches and decodes MIPS instructions and issues `func_code`, operand selects and write-back controls to the clocked ALU. It owns the PC and the instruction register. It handshakes with the instruction and data memory ports and steers register-file write-back. It is the controlling end of the ALU interface: it produces `func_code`, selects `a`/`b`, and consumes `zero` and the registered result.

---
 rtl/mips_alu_sequencer_if.sv | 41 ++++
 rtl/mips_alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_mips_alu_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_alu_sequencer_if.sv
// Bus bundle between the MIPS control sequencer and its environment:
// instruction/data memory handshakes, ALU controls and register write-back.
interface mips_alu_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic        dmem_waitrequest;
  logic [31:0] rs_data;
  logic        alu_zero;
  logic [5:0]  alu_func;
  logic        alu_b_imm;
  logic [31:0] imm_ext;
  logic        reg_write;
  logic [4:0]  reg_waddr;
  logic [1:0]  wb_sel;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        illegal;

  // The sequencer is the controlling end.
  modport master (
    output imem_req, input imem_ack, input imem_rdata,
    output dmem_read, output dmem_write, input dmem_waitrequest,
    input rs_data, input alu_zero,
    output alu_func, output alu_b_imm, output imm_ext,
    output reg_write, output reg_waddr, output wb_sel,
    output pc, output pc_plus4, output illegal
  );

  // Memories, register file and ALU side.
  modport slave (
    input imem_req, output imem_ack, output imem_rdata,
    input dmem_read, input dmem_write, output dmem_waitrequest,
    output rs_data, output alu_zero,
    input alu_func, input alu_b_imm, input imm_ext,
    input reg_write, input reg_waddr, input wb_sel,
    input pc, input pc_plus4, input illegal
  );
endinterface

// File: rtl/mips_alu_sequencer.sv
// Multi-cycle MIPS control sequencer: fetches into IR, decodes, issues ALU
// func codes and operand selects, runs data-memory handshakes and steers
// register-file write-back. Owns the PC.
module mips_alu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic clk,
  input  logic rst_n,
  mips_alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, RESOLVE, MEM, WB} state_t;
  typedef enum logic [3:0] {
    C_ILLEGAL, C_J, C_JAL, C_JR, C_ALU_R, C_ALU_I, C_BRANCH, C_LW, C_SW
  } cls_t;

  state_t      state, state_nx;
  cls_t        cls;
  logic [31:0] pc_q, pc_nx, pc_plus4_q, ir_q;
  logic [5:0]  func_q, dec_func;
  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, jump_target, branch_target;
  logic        zero_ext, taken;

  assign opcode        = ir_q[31:26];
  assign funct         = ir_q[5:0];
  assign imm_sext      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zero_ext      = (opcode == 6'b001100) || (opcode == 6'b001101) || (opcode == 6'b001110);
  assign jump_target   = {pc_plus4_q[31:28], ir_q[25:0], 2'b00};
  assign branch_target = pc_plus4_q + (imm_sext << 2);
  assign taken         = (opcode == 6'b000100) ? bus.alu_zero : !bus.alu_zero;

  // Classify the instruction in IR and pick the func code to issue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cls      = C_ILLEGAL;
    dec_func = 6'b100001;
    case (opcode)
      6'b000000: begin
        if (funct == 6'b001000) cls = C_JR;
        else begin
          case (funct)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011: begin
              cls      = C_ALU_R;
              dec_func = funct;
            end
            default: cls = C_ILLEGAL;
          endcase
        end
      end
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      6'b000100, 6'b000101: begin cls = C_BRANCH; dec_func = 6'b100011; end
      6'b001001: begin cls = C_ALU_I; dec_func = 6'b100001; end
      6'b001010: begin cls = C_ALU_I; dec_func = 6'b101010; end
      6'b001011: begin cls = C_ALU_I; dec_func = 6'b101011; end
      6'b001100: begin cls = C_ALU_I; dec_func = 6'b100100; end
      6'b001101: begin cls = C_ALU_I; dec_func = 6'b100101; end
      6'b001110: begin cls = C_ALU_I; dec_func = 6'b100110; end
      6'b100011: begin cls = C_LW;    dec_func = 6'b100001; end
      6'b101011: begin cls = C_SW;    dec_func = 6'b100001; end
      default:   cls = C_ILLEGAL;
    endcase
  end

  // Next state and next PC.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    case (state)
      FETCH:  if (bus.imem_ack) state_nx = DECODE;
      DECODE: begin
        case (cls)
          C_ILLEGAL: begin pc_nx = pc_plus4_q;  state_nx = FETCH; end
          C_J:       begin pc_nx = jump_target; state_nx = FETCH; end
          C_JAL:     begin pc_nx = jump_target; state_nx = WB;    end
          C_JR:      begin pc_nx = bus.rs_data; state_nx = FETCH; end
          default:   state_nx = EXEC;
        endcase
      end
      EXEC: begin
        if (cls == C_BRANCH)                 state_nx = RESOLVE;
        else if (cls == C_LW || cls == C_SW) state_nx = MEM;
        else                                 state_nx = WB;
      end
      RESOLVE: begin
        pc_nx    = taken ? branch_target : pc_plus4_q;
        state_nx = FETCH;
      end
      MEM: begin
        if (!bus.dmem_waitrequest) begin
          if (cls == C_LW) state_nx = WB;
          else begin
            pc_nx    = pc_plus4_q;
            state_nx = FETCH;
          end
        end
      end
      WB: begin
        // JAL already loaded its jump target in DECODE; keep it.
        if (cls != C_JAL) pc_nx = pc_plus4_q;
        state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // State, PC, IR and the held ALU func code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + PC_STEP;
      ir_q       <= '0;
      func_q     <= 6'b100001;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state <= state_nx;
      pc_q  <= pc_nx;
      if (state == FETCH && bus.imem_ack) begin
        ir_q       <= bus.imem_rdata;
        pc_plus4_q <= pc_q + PC_STEP;
      end
      if (state == DECODE && state_nx == EXEC) func_q <= dec_func;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once;
  // the fetch request is also held off while reset is asserted.
  assign bus.imem_req   = rst_n && (state == FETCH);
  assign bus.dmem_read  = (state == MEM) && (cls == C_LW);
  assign bus.dmem_write = (state == MEM) && (cls == C_SW);
  assign bus.reg_write  = (state == WB);
  assign bus.illegal    = (state == DECODE) && (cls == C_ILLEGAL);
  assign bus.alu_func   = func_q;
  assign bus.alu_b_imm  = (cls == C_ALU_I) || (cls == C_LW) || (cls == C_SW);
  assign bus.imm_ext    = zero_ext ? {16'h0000, ir_q[15:0]} : imm_sext;
  assign bus.reg_waddr  = (cls == C_JAL) ? 5'd31 : (cls == C_ALU_R) ? ir_q[15:11] : ir_q[20:16];
  assign bus.wb_sel     = (cls == C_JAL) ? 2'd2 : (cls == C_LW) ? 2'd1 : 2'd0;
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4_q;

endmodule

// File: tb/tb_mips_alu_sequencer.sv
// Self-checking bench for mips_alu_sequencer: directed scenarios plus random
// instruction streams compared against an instruction-level reference model.
module tb_mips_alu_sequencer;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic clk, rst_n;
  mips_alu_sequencer_if bus ();

  mips_alu_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected architectural effect of one instruction.
  typedef struct packed {
    int          cycles;
    logic        wr;
    logic [4:0]  waddr;
    logic [1:0]  wbsel;
    logic        ill;
    logic        ld;
    logic        st;
    logic        alu;
    logic [5:0]  func;
    logic        bimm;
    logic [31:0] imm;
    logic [31:0] p4;
    logic [31:0] npc;
  } exp_t;

  logic [31:0] exp_pc;
  logic [5:0]  r_functs [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0]  i_ops    [6]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};

  // Observations from the last run_instr call.
  int          obs_cycles, obs_wr, obs_ill, obs_rd, obs_wrm;
  logic [5:0]  obs_func;
  logic        obs_bimm;
  logic [31:0] obs_imm, obs_p4, obs_link, pc_start;
  logic [4:0]  obs_waddr;
  logic [1:0]  obs_wbsel;

  // Reference model: what one instruction does, in ISA terms.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins,
                                 input logic [31:0] rs, input logic zero);
    exp_t e;
    logic [5:0]  op, fn;
    logic [31:0] simm, tgt;
    op   = ins[31:26];
    fn   = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    e        = '0;
    e.p4     = pc + 32'd4;
    tgt      = {e.p4[31:28], ins[25:0], 2'b00};
    e.imm    = (op >= 6'h0C && op <= 6'h0E) ? {16'h0, ins[15:0]} : simm;
    e.ill    = 1'b1;
    e.cycles = 2;
    e.npc    = e.p4;
    if (op == 6'h00 && fn == 6'h08) begin
      e.ill = 0; e.npc = rs;
    end else if (op == 6'h00 && ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B)) begin
      e.ill = 0; e.cycles = 4; e.wr = 1; e.waddr = ins[15:11]; e.alu = 1; e.func = fn;
    end else if (op == 6'h02) begin
      e.ill = 0; e.npc = tgt;
    end else if (op == 6'h03) begin
      e.ill = 0; e.cycles = 3; e.wr = 1; e.waddr = 5'd31; e.wbsel = 2; e.npc = tgt;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.ill = 0; e.cycles = 4; e.alu = 1; e.func = 6'b100011;
      if ((op == 6'h04) == zero) e.npc = e.p4 + simm * 4;
    end else if (op >= 6'h09 && op <= 6'h0E) begin
      e.ill = 0; e.cycles = 4; e.wr = 1; e.waddr = ins[20:16]; e.alu = 1; e.bimm = 1;
      case (op)
        6'h09: e.func = 6'b100001;
        6'h0A: e.func = 6'b101010;
        6'h0B: e.func = 6'b101011;
        6'h0C: e.func = 6'b100100;
        6'h0D: e.func = 6'b100101;
        default: e.func = 6'b100110;
      endcase
    end else if (op == 6'h23) begin
      e.ill = 0; e.cycles = 5; e.wr = 1; e.waddr = ins[20:16]; e.wbsel = 1;
      e.ld = 1; e.alu = 1; e.bimm = 1; e.func = 6'b100001;
    end else if (op == 6'h2B) begin
      e.ill = 0; e.cycles = 4; e.st = 1; e.alu = 1; e.bimm = 1; e.func = 6'b100001;
    end
    return e;
  endfunction

  // Wait (bounded) for a fetch request; returns 0 on timeout.
  task automatic wait_fetch(output bit ok);
    int k = 0;
    while (bus.imem_req !== 1'b1 && k < 20) begin
      bus.imem_ack = 1'b0;
      @(negedge clk);
      k++;
    end
    bus.imem_ack = 1'b0;
    ok = (bus.imem_req === 1'b1);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_timeout: imem_req=%b required 1", bus.imem_req);
    end
  endtask

  // Feed one instruction and follow it until the next fetch, checking against the model.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] rs, input logic zero,
                           input int ack_delay, input int wait_n);
    exp_t e;
    bit   ok, done;
    int   n, k, left;
    e = model(exp_pc, ins, rs, zero);
    bus.rs_data = rs; bus.alu_zero = zero; bus.dmem_waitrequest = 1'b0;
    wait_fetch(ok);
    if (!ok) return;
    pc_start = bus.pc;
    n_cmp++;
    if (bus.pc !== exp_pc) begin n_bad++; $display("FAIL fetch_pc: got %h required %h", bus.pc, exp_pc); end
    n = 0;
    repeat (ack_delay) begin @(negedge clk); n++; end
    bus.imem_ack = 1'b1; bus.imem_rdata = ins;
    @(negedge clk); n++;
    bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
    obs_wr = 0; obs_ill = 0; obs_rd = 0; obs_wrm = 0;
    obs_func = 'x; obs_bimm = 'x; obs_imm = 'x; obs_p4 = 'x; obs_link = 'x;
    obs_waddr = 'x; obs_wbsel = 'x;
    k = 1; done = 0; left = wait_n;
    while (!done && k < 60) begin
      if (bus.imem_req === 1'b1) begin
        done = 1; bus.imem_ack = 1'b0;
      end else begin
        if (k == 1) begin obs_p4 = bus.pc_plus4; obs_imm = bus.imm_ext; end
        if (k == 2) begin obs_func = bus.alu_func; obs_bimm = bus.alu_b_imm; end
        if (bus.reg_write === 1'b1) begin
          obs_wr++; obs_waddr = bus.reg_waddr; obs_wbsel = bus.wb_sel; obs_link = bus.pc_plus4;
        end
        if (bus.illegal === 1'b1) obs_ill++;
        if (bus.dmem_read === 1'b1) obs_rd++;
        if (bus.dmem_write === 1'b1) obs_wrm++;
        if (bus.dmem_read === 1'b1 || bus.dmem_write === 1'b1) begin
          bus.dmem_waitrequest = (left > 0);
          if (left > 0) left--;
        end else bus.dmem_waitrequest = 1'b0;
        bus.imem_ack = 1'($urandom_range(0, 1));  // must be ignored outside FETCH
        n++;
        @(negedge clk); k++;
      end
    end
    obs_cycles = n;
    exp_pc = e.npc;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL instr_timeout: instr %h never returned to fetch", ins);
      return;
    end
    n_cmp++;
    if (n !== e.cycles + ack_delay + ((e.ld || e.st) ? wait_n : 0)) begin
      n_bad++; $display("FAIL cycles: instr %h got %0d required %0d", ins, n,
                        e.cycles + ack_delay + ((e.ld || e.st) ? wait_n : 0));
    end
    n_cmp++;
    if (obs_wr !== (e.wr ? 1 : 0)) begin n_bad++; $display("FAIL reg_write_count: instr %h got %0d required %0d", ins, obs_wr, e.wr); end
    if (e.wr) begin
      n_cmp++;
      if (obs_waddr !== e.waddr || obs_wbsel !== e.wbsel) begin
        n_bad++; $display("FAIL wb_ctrl: instr %h got waddr %0d sel %0d required %0d %0d", ins, obs_waddr, obs_wbsel, e.waddr, e.wbsel);
      end
    end
    if (e.wbsel == 2'd2) begin
      n_cmp++;
      if (obs_link !== e.p4) begin n_bad++; $display("FAIL link: got %h required %h", obs_link, e.p4); end
    end
    n_cmp++;
    if (obs_ill !== (e.ill ? 1 : 0)) begin n_bad++; $display("FAIL illegal_count: instr %h got %0d required %0d", ins, obs_ill, e.ill); end
    n_cmp++;
    if (obs_rd !== (e.ld ? wait_n + 1 : 0) || obs_wrm !== (e.st ? wait_n + 1 : 0)) begin
      n_bad++; $display("FAIL dmem_cycles: instr %h got rd %0d wr %0d required %0d %0d", ins, obs_rd, obs_wrm,
                        e.ld ? wait_n + 1 : 0, e.st ? wait_n + 1 : 0);
    end
    if (e.alu) begin
      n_cmp++;
      if (obs_func !== e.func || obs_bimm !== e.bimm) begin
        n_bad++; $display("FAIL alu_issue: instr %h got func %b bimm %b required %b %b", ins, obs_func, obs_bimm, e.func, e.bimm);
      end
    end
    n_cmp++;
    if (obs_imm !== e.imm) begin n_bad++; $display("FAIL imm_ext: instr %h got %h required %h", ins, obs_imm, e.imm); end
    n_cmp++;
    if (obs_p4 !== e.p4) begin n_bad++; $display("FAIL pc_plus4: got %h required %h", obs_p4, e.p4); end
    n_cmp++;
    if (bus.pc !== e.npc) begin n_bad++; $display("FAIL next_pc: instr %h got %h required %h", ins, bus.pc, e.npc); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.imem_req, bus.dmem_read, bus.dmem_write, bus.reg_write, bus.illegal} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b required 00000",
                        {bus.imem_req, bus.dmem_read, bus.dmem_write, bus.reg_write, bus.illegal});
    end
    n_cmp++;
    if (bus.alu_func !== 6'b100001) begin n_bad++; $display("FAIL reset_func: got %b required 100001", bus.alu_func); end
    n_cmp++;
    if (bus.pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc: got %h required %h", bus.pc, RESET_PC); end
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_instr(32'h00851020, 32'h0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_func !== 6'b100000 || obs_waddr !== 5'd2 || obs_wbsel !== 2'd0 || obs_cycles !== 4) begin
      n_bad++; $display("FAIL add: got func %b waddr %0d sel %0d cycles %0d required 100000 2 0 4", obs_func, obs_waddr, obs_wbsel, obs_cycles);
    end
    n_cmp++;
    if (bus.pc !== 32'hBFC00004) begin n_bad++; $display("FAIL add_pc: got %h required bfc00004", bus.pc); end
  endtask

  task automatic test_imm();
    run_instr(32'h3482FFFF, 32'h0, 1'b0, 1, 0);
    n_cmp++;
    if (obs_func !== 6'b100101 || obs_bimm !== 1'b1 || obs_imm !== 32'h0000FFFF || obs_waddr !== 5'd2) begin
      n_bad++; $display("FAIL ori: got func %b bimm %b imm %h waddr %0d", obs_func, obs_bimm, obs_imm, obs_waddr);
    end
    run_instr(32'h2482FFFF, 32'h0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_imm !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL addiu_imm: got %h required ffffffff", obs_imm); end
  endtask

  task automatic test_branch();
    logic [31:0] ins;
    for (int b = 0; b < 2; b++) begin
      for (int z = 0; z < 2; z++) begin
        ins = (b == 0) ? 32'h1000FFFF : 32'h1400FFFF;
        run_instr(ins, 32'h0, 1'(z), 0, 0);
        n_cmp++;
        // Taken with offset -1 word lands back on the branch itself.
        if (bus.pc !== (((b == 0) == (z == 1)) ? pc_start : pc_start + 32'd4)) begin
          n_bad++; $display("FAIL branch_outcome: bne=%0d zero=%0d got %h start %h", b, z, bus.pc, pc_start);
        end
      end
    end
  endtask

  task automatic test_mem();
    run_instr(32'h8C820000, 32'h0, 1'b0, 0, 3);
    n_cmp++;
    if (obs_rd !== 4 || obs_wbsel !== 2'd1 || obs_cycles !== 8) begin
      n_bad++; $display("FAIL lw_wait: got read %0d sel %0d cycles %0d required 4 1 8", obs_rd, obs_wbsel, obs_cycles);
    end
    run_instr(32'hAC820000, 32'h0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_wr !== 0 || obs_cycles !== 4) begin n_bad++; $display("FAIL sw: got writes %0d cycles %0d required 0 4", obs_wr, obs_cycles); end
  endtask

  task automatic test_jumps();
    run_instr(32'h00800008, 32'h00001234, 1'b0, 0, 0);
    n_cmp++;
    if (bus.pc !== 32'h00001234 || obs_cycles !== 2) begin n_bad++; $display("FAIL jr: got pc %h cycles %0d required 00001234 2", bus.pc, obs_cycles); end
    run_instr(32'h00800008, 32'h00400000, 1'b0, 0, 0);
    run_instr(32'h0C100000, 32'h0, 1'b0, 0, 0);
    n_cmp++;
    if (bus.pc !== 32'h00400000 || obs_waddr !== 5'd31 || obs_wbsel !== 2'd2 || obs_cycles !== 3) begin
      n_bad++; $display("FAIL jal: got pc %h waddr %0d sel %0d cycles %0d", bus.pc, obs_waddr, obs_wbsel, obs_cycles);
    end
  endtask

  task automatic test_illegal();
    run_instr(32'hFC000000, 32'h0, 1'b0, 0, 0);
    n_cmp++;
    if (obs_ill !== 1 || bus.pc !== pc_start + 32'd4) begin n_bad++; $display("FAIL illegal: got pulses %0d pc %h", obs_ill, bus.pc); end
  endtask

  task automatic test_wrap();
    run_instr(32'h00800008, 32'hFFFFFFFC, 1'b0, 0, 0);
    run_instr(32'h00851020, 32'h0, 1'b0, 0, 0);
    n_cmp++;
    if (bus.pc !== 32'h0 || obs_p4 !== 32'h0) begin n_bad++; $display("FAIL pc_wrap: got pc %h p4 %h required 0 0", bus.pc, obs_p4); end
  endtask

  task automatic test_reset_mid_mem();
    bit ok;
    int k;
    wait_fetch(ok);
    if (!ok) return;
    bus.dmem_waitrequest = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C820000;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    k = 0;
    while (bus.dmem_read !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (bus.dmem_read !== 1'b1) begin n_bad++; $display("FAIL mid_mem_reach: dmem_read=%b required 1", bus.dmem_read); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.dmem_read !== 1'b0 || bus.pc !== RESET_PC || bus.reg_write !== 1'b0) begin
      n_bad++; $display("FAIL mid_mem_reset: got read %b pc %h wr %b", bus.dmem_read, bus.pc, bus.reg_write);
    end
    @(negedge clk);
    bus.dmem_waitrequest = 1'b0;
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    // The next fetch starts from RESET_PC with no write-back in between.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL post_reset_wb: reg_write=%b required 0", bus.reg_write); end
    end
    run_instr(32'h00851020, 32'h0, 1'b0, 0, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    return {6'h00, r[25:11], 5'd0, r_functs[$urandom_range(0, 9)]};
      2, 3:    return {i_ops[$urandom_range(0, 5)], r[25:0]};
      4:       return {r[31] ? 6'h05 : 6'h04, r[25:0]};
      5:       return {6'h23, r[25:0]};
      6:       return {6'h2B, r[25:0]};
      7:       return {r[31] ? 6'h03 : 6'h02, r[25:0]};
      8:       return {6'h00, r[25:21], 15'd0, 6'h08};
      default: return r;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      run_instr(rand_instr(), $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_waitrequest = 1'b0;
    bus.rs_data = '0; bus.alu_zero = 1'b0;
    exp_pc = RESET_PC;
    @(negedge clk);
    test_reset();
    test_add();
    test_imm();
    test_branch();
    test_mem();
    test_jumps();
    test_illegal();
    test_wrap();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
